// File: rtl/reg_context_switcher.sv
// Sequences register-file snapshot (Save/Dump) and reload (Load/LDump) so that
// NUM_CTX complete register images can be parked in and restored from an on-chip store.
module reg_context_switcher #(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = 2,
  parameter int IMG_W   = 992
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [CTX_W-1:0]   req_ctx,
  output logic               done,
  output logic               err,
  output logic [CTX_W-1:0]   cur_ctx,
  output logic [NUM_CTX-1:0] valid_mask,
  output logic               rf_stall,
  output logic               rf_save,
  output logic               rf_load,
  input  logic [IMG_W-1:0]   rf_dump_in,
  output logic [IMG_W-1:0]   rf_ldump_out
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_REQ,
    SAVE_CAP,
    LOAD_DRV,
    DONE
  } state_t;

  localparam logic [1:0] OP_SAVE    = 2'b00;
  localparam logic [1:0] OP_RESTORE = 2'b01;
  localparam logic [1:0] OP_SWITCH  = 2'b10;

  state_t           state, stateNext;
  logic [1:0]       opReg;
  logic [CTX_W-1:0] tgtCtx;
  logic             errReg;
  logic             reqErr;
  logic [CTX_W-1:0] saveSlot;
  logic [CTX_W-1:0] loadSrc;
  logic [IMG_W-1:0] ctxStore [NUM_CTX];

  // A restore or switch may only name a slot that already holds an image.
  always_comb begin
    reqErr = 1'b0;
    if (req_op == 2'b11) begin
      reqErr = 1'b1;
    end else if (req_op != OP_SAVE && !valid_mask[req_ctx]) begin
      reqErr = 1'b1;
    end
  end

  assign saveSlot = (opReg == OP_SWITCH) ? cur_ctx : tgtCtx;
  assign loadSrc  = (state == IDLE) ? req_ctx : tgtCtx;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (reqErr) begin
            stateNext = DONE;
          end else if (req_op == OP_RESTORE) begin
            stateNext = LOAD_DRV;
          end else begin
            stateNext = SAVE_REQ;
          end
        end
      end
      SAVE_REQ: stateNext = SAVE_CAP;
      SAVE_CAP: begin
        if (opReg == OP_SWITCH && tgtCtx != cur_ctx) begin
          stateNext = LOAD_DRV;
        end else begin
          stateNext = DONE;
        end
      end
      LOAD_DRV: stateNext = DONE;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Control state: FSM, slot bookkeeping and the registered LDump image.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      errReg       <= 1'b0;
      cur_ctx      <= '0;
      valid_mask   <= '0;
      rf_ldump_out <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req_valid) begin
        errReg <= reqErr;
      end
      if (state == SAVE_CAP) begin
        valid_mask[saveSlot] <= 1'b1;
      end
      // Loaded on entry so the image is settled before the mid-cycle Load strobe.
      if (stateNext == LOAD_DRV) begin
        rf_ldump_out <= ctxStore[loadSrc];
      end
      if (state == LOAD_DRV) begin
        cur_ctx <= tgtCtx;
      end
    end
  end

  // Request fields and context images carry no reset; valid_mask defines validity.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req_valid) begin
      opReg  <= req_op;
      tgtCtx <= req_ctx;
    end
    if (state == SAVE_CAP) begin
      ctxStore[saveSlot] <= rf_dump_in;
    end
  end

  assign req_ready = (state == IDLE);
  assign rf_stall  = (state != IDLE);
  assign rf_save   = (state == SAVE_REQ);
  assign rf_load   = (state == LOAD_DRV);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && errReg;

endmodule

// File: tb/tb_reg_context_switcher.sv
// Directed bench for reg_context_switcher: a transaction-level model predicts every
// cycle's outputs, and literal expectations pin the model on the key scenarios.
module tb_reg_context_switcher;

  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;
  localparam int IMG_W   = 992;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b1;
  logic               req_valid = 1'b0;
  logic [1:0]         req_op = 2'b00;
  logic [CTX_W-1:0]   req_ctx = '0;
  logic               req_ready, done, err, rf_stall, rf_save, rf_load;
  logic [CTX_W-1:0]   cur_ctx;
  logic [NUM_CTX-1:0] valid_mask;
  logic [IMG_W-1:0]   dumpImg = '0;
  logic [IMG_W-1:0]   rf_ldump_out;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  reg_context_switcher #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .IMG_W(IMG_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_ctx(req_ctx),
    .done(done), .err(err), .cur_ctx(cur_ctx), .valid_mask(valid_mask),
    .rf_stall(rf_stall), .rf_save(rf_save), .rf_load(rf_load),
    .rf_dump_in(dumpImg), .rf_ldump_out(rf_ldump_out)
  );

  typedef struct {
    bit                 save;
    bit                 load;
    bit                 done;
    bit                 err;
    logic [NUM_CTX-1:0] mask;
    logic [CTX_W-1:0]   cur;
    logic [IMG_W-1:0]   ld;
  } ent_t;

  ent_t               expQ[$];
  logic [IMG_W-1:0]   mStore [NUM_CTX];
  logic [NUM_CTX-1:0] mMask = '0;
  logic [CTX_W-1:0]   mCur = '0;
  logic [IMG_W-1:0]   mLd = '0;
  bit                 justDone = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chkImg(input string nm, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got[127:0]=%h want[127:0]=%h", nm, act[127:0], exp[127:0]);
    end
  endtask

  task automatic failNow(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=timeout want=event", nm);
  endtask

  function automatic logic [IMG_W-1:0] mkImg(input int base);
    logic [IMG_W-1:0] r;
    r = '0;
    for (int n = 1; n <= 31; n++) r[32*(n-1) +: 32] = 32'(n + base);
    return r;
  endfunction

  function automatic ent_t curEnt();
    ent_t e;
    e.save = 0; e.load = 0; e.done = 0; e.err = 0;
    e.mask = mMask; e.cur = mCur; e.ld = mLd;
    return e;
  endfunction

  // Expand one accepted request into its per-cycle expected outputs.
  task automatic build(input logic [1:0] op, input logic [CTX_W-1:0] ctx);
    ent_t e;
    logic [CTX_W-1:0] tgt;
    e = curEnt();
    if (op == 2'b11 || (op != 2'b00 && !mMask[ctx])) begin
      e.done = 1; e.err = 1; expQ.push_back(e);
    end else if (op == 2'b01) begin
      e.load = 1; e.ld = mStore[ctx]; expQ.push_back(e);
      e.load = 0; e.done = 1; e.cur = ctx; expQ.push_back(e);
    end else begin
      tgt = (op == 2'b00) ? ctx : mCur;
      e.save = 1; expQ.push_back(e);
      e.save = 0; expQ.push_back(e);
      e.mask = mMask | (NUM_CTX'(1) << tgt);
      if (op == 2'b10 && ctx != mCur) begin
        e.load = 1; e.ld = mStore[ctx]; expQ.push_back(e);
        e.load = 0;
      end
      mStore[tgt] = dumpImg;
      e.done = 1;
      if (op == 2'b10) e.cur = ctx;
      expQ.push_back(e);
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      expQ.delete();
      mMask = '0; mCur = '0; mLd = '0; justDone = 0;
    end else if (req_valid && expQ.size() == 0 && !justDone) begin
      build(req_op, req_ctx);
    end
  end

  always @(negedge CLK) begin
    ent_t e;
    bit idle;
    if (expQ.size() > 0) begin
      e = expQ.pop_front(); idle = 0;
    end else begin
      e = curEnt(); idle = 1;
    end
    chk("m_ready", req_ready, idle);
    chk("m_stall", rf_stall, !idle);
    chk("m_save", rf_save, e.save);
    chk("m_load", rf_load, e.load);
    chk("m_done", done, e.done);
    if (e.done) chk("m_err", err, e.err);
    chk("m_cur", cur_ctx, e.cur);
    chk("m_mask", valid_mask, e.mask);
    chkImg("m_ldump", rf_ldump_out, e.ld);
    if (!idle) begin
      mMask = e.mask; mCur = e.cur; mLd = e.ld;
    end
    justDone = e.done;
  end

  task automatic doReq(input logic [1:0] op, input logic [CTX_W-1:0] ctx, output int lat,
                       output logic [7:0] sv, output logic [7:0] ld, output logic [7:0] st,
                       output logic er);
    int n;
    lat = 0; sv = '0; ld = '0; st = '0; er = 1'b0;
    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      failNow("req_ready_wait");
      return;
    end
    req_valid = 1'b1; req_op = op; req_ctx = ctx;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      sv[k] = rf_save; ld[k] = rf_load; st[k] = rf_stall;
      if (done) begin
        lat = k; er = err;
        break;
      end
    end
    if (lat == 0) failNow("done_wait");
  endtask

  initial begin
    int lat;
    logic [7:0] sv, ld, st, rdy;
    logic er;

    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_stall", rf_stall, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", valid_mask, 0);
    chk("rst_cur", cur_ctx, 0);
    chkImg("rst_ldump", rf_ldump_out, '0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ready", req_ready, 1);

    // Test 1: SAVE ctx 2 with Rn=n
    dumpImg = mkImg(0);
    doReq(2'b00, 2'd2, lat, sv, ld, st, er);
    chk("t1_lat", lat, 3);
    chk("t1_err", er, 0);
    chk("t1_save", sv, 8'h02);
    chk("t1_load", ld, 8'h00);
    chk("t1_mask", valid_mask, 4'b0100);
    chk("t1_cur", cur_ctx, 0);

    // Test 2: registers overwritten, RESTORE ctx 2
    dumpImg = '1;
    doReq(2'b01, 2'd2, lat, sv, ld, st, er);
    chk("t2_lat", lat, 2);
    chk("t2_load", ld, 8'h02);
    chk("t2_save", sv, 8'h00);
    chk("t2_cur", cur_ctx, 2);
    chk("t2_r1", rf_ldump_out[31:0], 1);
    chk("t2_r31", rf_ldump_out[991:960], 31);
    chkImg("t2_img", rf_ldump_out, mkImg(0));

    // Test 3: RESTORE of an empty slot and the reserved op
    doReq(2'b01, 2'd3, lat, sv, ld, st, er);
    chk("t3a_lat", lat, 1);
    chk("t3a_err", er, 1);
    chk("t3a_strobes", {sv, ld}, 16'h0);
    chk("t3a_cur", cur_ctx, 2);
    doReq(2'b11, 2'd0, lat, sv, ld, st, er);
    chk("t3b_lat", lat, 1);
    chk("t3b_err", er, 1);
    chk("t3b_strobes", {sv, ld}, 16'h0);
    chk("t3b_cur", cur_ctx, 2);

    // Test 4: make ctx 1 valid, then SWITCH to it twice
    doReq(2'b00, 2'd1, lat, sv, ld, st, er);
    chk("t4_pre_mask", valid_mask, 4'b0110);
    dumpImg = mkImg(100);
    doReq(2'b10, 2'd1, lat, sv, ld, st, er);
    chk("t4_lat", lat, 4);
    chk("t4_err", er, 0);
    chk("t4_save", sv, 8'h02);
    chk("t4_load", ld, 8'h08);
    chk("t4_stall", st, 8'h1E);
    chk("t4_cur", cur_ctx, 1);
    chkImg("t4_img", rf_ldump_out, '1);
    doReq(2'b10, 2'd1, lat, sv, ld, st, er);
    chk("t4b_lat", lat, 3);
    chk("t4b_load", ld, 8'h00);
    chk("t4b_cur", cur_ctx, 1);
    doReq(2'b01, 2'd2, lat, sv, ld, st, er);
    chk("t4c_r1", rf_ldump_out[31:0], 101);
    chk("t4c_cur", cur_ctx, 2);

    // Test 5: req_valid held high with changing ctx while busy
    @(negedge CLK);
    req_valid = 1'b1; req_op = 2'b00; req_ctx = 2'd0;
    @(posedge CLK);
    lat = 0; rdy = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      rdy[k] = req_ready;
      if (done) begin
        lat = k; req_valid = 1'b0;
        break;
      end
      req_ctx = CTX_W'(k);
    end
    req_valid = 1'b0;
    if (lat == 0) failNow("t5_done_wait");
    chk("t5_lat", lat, 3);
    chk("t5_busy_ready", rdy, 8'h00);
    chk("t5_mask", valid_mask, 4'b0111);
    @(negedge CLK);
    chk("t5_ready_after", req_ready, 1);

    // Test 6: reset during LOAD_DRV
    @(negedge CLK);
    req_valid = 1'b1; req_op = 2'b01; req_ctx = 2'd1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    #1 chk("t6_load_pre", rf_load, 1);
    RST_N = 1'b0;
    #1;
    chk("t6_load", rf_load, 0);
    chk("t6_stall", rf_stall, 0);
    chk("t6_done", done, 0);
    chk("t6_mask", valid_mask, 0);
    chk("t6_cur", cur_ctx, 0);
    chkImg("t6_ldump", rf_ldump_out, '0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("t6_ready", req_ready, 1);
    doReq(2'b01, 2'd2, lat, sv, ld, st, er);
    chk("t6_post_lat", lat, 1);
    chk("t6_post_err", er, 1);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
